// File: rtl/sti_rcv.sv
// sti_rcv: STI serial-to-parallel receiver.
// Deserialises 8/16/24/32-bit frames (MSB- or LSB-first) from a qualified
// serial bit stream into a right-aligned 32-bit word with a one-cycle strobe.
//
// Optional feature macro: STI_RCV_GAP_EN
//   defined   - in-frame idle gaps longer than GAP_MAX cycles abort the frame
//               and pulse frame_err.
//   undefined - gaps of any length are tolerated; frame_err is constant 0.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   si_data    serial data bit, sampled when si_valid=1
//   si_valid   serial bit qualifier
//   cfg_load   latch cfg_length/cfg_msb (accepted only while idle)
//   cfg_length frame length: 00=8, 01=16, 10=24, 11=32 bits
//   cfg_msb    1 = first bit is word MSB, 0 = first bit is bit 0
//   po_data    received word, right-aligned, upper bits zero
//   po_valid   one-cycle strobe qualifying po_data
//   po_count   completed-frame counter (wraps)
//   busy       high while a frame is partially received
//   frame_err  one-cycle gap-abort strobe (0 without STI_RCV_GAP_EN)
module sti_rcv #(
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned GAP_MAX = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             si_data,
   input  logic             si_valid,
   input  logic             cfg_load,
   input  logic [1:0]       cfg_length,
   input  logic             cfg_msb,
   output logic [31:0]      po_data,
   output logic             po_valid,
   output logic [CNT_W-1:0] po_count,
   output logic             busy,
   output logic             frame_err
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BCNT_W = 6;

   typedef enum logic {IDLE, RECV} state_t;

   state_t             state, state_n;
   logic [WORD_W-1:0]  sh, sh_n;
   logic [BCNT_W-1:0]  bit_cnt, bit_cnt_n;
   logic [BCNT_W-1:0]  n_bits;
   logic [1:0]         lat_len, lat_len_n;
   logic               lat_msb, lat_msb_n;
   logic [WORD_W-1:0]  po_data_n;
   logic               po_valid_n;
   logic [CNT_W-1:0]   po_count_n;
   logic               busy_n;

`ifdef STI_RCV_GAP_EN
   localparam int unsigned GAP_W = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
   logic [GAP_W-1:0]   gap, gap_n;
   logic               frame_err_r, frame_err_n;
   assign frame_err = frame_err_r;
`else
   assign frame_err = 1'b0;
`endif

   // Frame length in bits from the latched configuration
   always_comb begin
      case (lat_len)
         2'b00:   n_bits = BCNT_W'(8);
         2'b01:   n_bits = BCNT_W'(16);
         2'b10:   n_bits = BCNT_W'(24);
         default: n_bits = BCNT_W'(32);
      endcase
   end

   // Next-state and output logic
   always_comb begin
      state_n    = state;
      sh_n       = sh;
      bit_cnt_n  = bit_cnt;
      lat_len_n  = lat_len;
      lat_msb_n  = lat_msb;
      po_data_n  = po_data;
      po_valid_n = 1'b0;
      po_count_n = po_count;
`ifdef STI_RCV_GAP_EN
      gap_n       = gap;
      frame_err_n = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (cfg_load) begin
               lat_len_n = cfg_length;
               lat_msb_n = cfg_msb;
            end
            // First bit lands in bit 0 for either bit order
            if (si_valid) begin
               sh_n      = {31'b0, si_data};
               bit_cnt_n = BCNT_W'(1);
               state_n   = RECV;
`ifdef STI_RCV_GAP_EN
               gap_n     = '0;
`endif
            end
         end

         RECV: begin
            if (si_valid) begin
`ifdef STI_RCV_GAP_EN
               gap_n = '0;
`endif
               if (lat_msb) sh_n = {sh[WORD_W-2:0], si_data};
               else         sh_n[bit_cnt[4:0]] = si_data;
               bit_cnt_n = bit_cnt + BCNT_W'(1);
               if (bit_cnt_n == n_bits) begin
                  po_data_n  = sh_n;
                  po_valid_n = 1'b1;
                  po_count_n = po_count + CNT_W'(1);
                  state_n    = IDLE;
                  bit_cnt_n  = '0;
                  sh_n       = '0;
               end
            end
`ifdef STI_RCV_GAP_EN
            // GAP_MAX+1-th consecutive idle cycle aborts the frame
            else if (gap == GAP_W'(GAP_MAX)) begin
               frame_err_n = 1'b1;
               state_n     = IDLE;
               bit_cnt_n   = '0;
               sh_n        = '0;
               gap_n       = '0;
            end else begin
               gap_n = gap + GAP_W'(1);
            end
`endif
         end

         default: state_n = IDLE;
      endcase

      busy_n = (state_n == RECV);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         sh       <= '0;
         bit_cnt  <= '0;
         lat_len  <= 2'b00;
         lat_msb  <= 1'b1;
         po_data  <= '0;
         po_valid <= 1'b0;
         po_count <= '0;
         busy     <= 1'b0;
`ifdef STI_RCV_GAP_EN
         gap         <= '0;
         frame_err_r <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         sh       <= sh_n;
         bit_cnt  <= bit_cnt_n;
         lat_len  <= lat_len_n;
         lat_msb  <= lat_msb_n;
         po_data  <= po_data_n;
         po_valid <= po_valid_n;
         po_count <= po_count_n;
         busy     <= busy_n;
`ifdef STI_RCV_GAP_EN
         gap         <= gap_n;
         frame_err_r <= frame_err_n;
`endif
      end
   end

endmodule

// File: tb/tb_sti_rcv.sv
// tb_sti_rcv: directed, table-driven bench for sti_rcv plus hand-written
// sequences for back-to-back frames, ignored cfg_load, gaps, counter wrap
// and mid-frame reset. CNT_W is reduced to 4 so the counter wrap is reached.
module tb_sti_rcv;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             si_data;
   logic             si_valid;
   logic             cfg_load;
   logic [1:0]       cfg_length;
   logic             cfg_msb;
   logic [31:0]      po_data;
   logic             po_valid;
   logic [CNT_W-1:0] po_count;
   logic             busy;
   logic             frame_err;

   sti_rcv #(.CNT_W(CNT_W), .GAP_MAX(15)) dut (
      .clk(clk), .reset(reset), .si_data(si_data), .si_valid(si_valid),
      .cfg_load(cfg_load), .cfg_length(cfg_length), .cfg_msb(cfg_msb),
      .po_data(po_data), .po_valid(po_valid), .po_count(po_count),
      .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  len;
      logic        msb;
      logic        do_cfg;
      logic        same_edge;
      logic [31:0] word;
      int          gap_pos;
      int          gap_len;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[8];
   int n_vec = 0;
   int n_err = 0;
   int exp_count = 0;
   logic [31:0] last_data = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic send_bit(input logic b);
      si_valid = 1'b1;
      si_data  = b;
      tick();
      si_valid = 1'b0;
   endtask

   function automatic logic frame_bit(input logic [31:0] w, input int n, input logic msb, input int i);
      return msb ? w[n-1-i] : w[i];
   endfunction

   function automatic logic [31:0] exp_cnt();
      return 32'(exp_count % (1 << CNT_W));
   endfunction

   // One complete frame, with optional in-frame gap, then one idle cycle
   task automatic run_vec(input vec_t v, input string nm);
      int n;
      n = 8 * (int'(v.len) + 1);
      if (v.do_cfg && !v.same_edge) begin
         cfg_load = 1'b1; cfg_length = v.len; cfg_msb = v.msb;
         tick();
         cfg_load = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         if (i == 0 && v.same_edge) begin
            cfg_load = 1'b1; cfg_length = v.len; cfg_msb = v.msb;
         end
         send_bit(frame_bit(v.word, n, v.msb, i));
         cfg_load = 1'b0;
         if (i < n - 1) begin
            chk({nm, " mid po_valid"}, 32'(po_valid), 32'd0);
            if (i + 1 == v.gap_pos) begin
               for (int g = 0; g < v.gap_len; g++) tick();
               chk({nm, " gap busy"}, 32'(busy), 32'd1);
               chk({nm, " gap po_valid"}, 32'(po_valid), 32'd0);
               chk({nm, " gap frame_err"}, 32'(frame_err), 32'd0);
            end
         end
      end
      exp_count++;
      chk({nm, " po_valid"}, 32'(po_valid), 32'd1);
      chk({nm, " po_data"}, po_data, v.exp_data);
      chk({nm, " po_count"}, 32'(po_count), exp_cnt());
      chk({nm, " busy"}, 32'(busy), 32'd0);
      last_data = v.exp_data;
      tick();
      chk({nm, " po_valid drop"}, 32'(po_valid), 32'd0);
      chk({nm, " po_data hold"}, po_data, v.exp_data);
   endtask

   initial begin
      logic [15:0] w16;
      logic [7:0]  w8;
      vec_t        v;

      //          len    msb  cfg  same  word           gpos glen exp
      vecs[0] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_00A5,  0,  0, 32'h0000_00A5};
      vecs[1] = '{2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_1234,  0,  0, 32'h0000_1234};
      vecs[2] = '{2'b11, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 12,  3, 32'hDEAD_BEEF};
      vecs[3] = '{2'b10, 1'b0, 1'b1, 1'b1, 32'h00AB_CDEF,  0,  0, 32'h00AB_CDEF};
      vecs[4] = '{2'b11, 1'b0, 1'b1, 1'b0, 32'h8000_0001, 31, 15, 32'h8000_0001};
      vecs[5] = '{2'b00, 1'b0, 1'b1, 1'b1, 32'h0000_003C,  0,  0, 32'h0000_003C};
      vecs[6] = '{2'b01, 1'b1, 1'b1, 1'b0, 32'hFFFF_8001,  0,  0, 32'h0000_8001};
      vecs[7] = '{2'b10, 1'b1, 1'b1, 1'b0, 32'h00FF_FFFF,  5,  2, 32'h00FF_FFFF};

      reset = 1'b1; si_data = 1'b0; si_valid = 1'b0;
      cfg_load = 1'b0; cfg_length = 2'b00; cfg_msb = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst po_data", po_data, 32'd0);
      chk("rst po_valid", 32'(po_valid), 32'd0);
      chk("rst po_count", 32'(po_count), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst frame_err", 32'(frame_err), 32'd0);
      tick();

      for (int k = 0; k < 8; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // cfg_load while receiving is ignored: 8-bit MSB-first 0x96
      cfg_load = 1'b1; cfg_length = 2'b00; cfg_msb = 1'b1;
      tick();
      cfg_load = 1'b0;
      w8 = 8'h96;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            cfg_load = 1'b1; cfg_length = 2'b11; cfg_msb = 1'b0;
         end
         send_bit(w8[7-i]);
         cfg_load = 1'b0;
      end
      exp_count++;
      chk("cfgign po_valid", 32'(po_valid), 32'd1);
      chk("cfgign po_data", po_data, 32'h0000_0096);

      // Back-to-back 0x5A, 0xC3 with no idle between frames
      w16 = 16'h5AC3;
      for (int i = 0; i < 16; i++) begin
         send_bit(w16[15-i]);
         if (i == 7) begin
            exp_count++;
            chk("b2b first po_valid", 32'(po_valid), 32'd1);
            chk("b2b first po_data", po_data, 32'h0000_005A);
            chk("b2b first busy", 32'(busy), 32'd0);
         end else if (i == 8) begin
            chk("b2b next busy", 32'(busy), 32'd1);
            chk("b2b next po_valid", 32'(po_valid), 32'd0);
         end else if (i == 15) begin
            exp_count++;
            chk("b2b second po_valid", 32'(po_valid), 32'd1);
            chk("b2b second po_data", po_data, 32'h0000_00C3);
            chk("b2b po_count", 32'(po_count), exp_cnt());
         end else begin
            chk("b2b mid po_valid", 32'(po_valid), 32'd0);
         end
      end
      tick();

`ifdef STI_RCV_GAP_EN
      // 16-cycle stall after bit 5 aborts; 15-cycle stall is tolerated
      cfg_load = 1'b1; cfg_length = 2'b01; cfg_msb = 1'b1;
      tick();
      cfg_load = 1'b0;
      w16 = 16'h1234;
      for (int i = 0; i < 5; i++) send_bit(w16[15-i]);
      for (int g = 0; g < 15; g++) tick();
      chk("gap15 frame_err", 32'(frame_err), 32'd0);
      chk("gap15 busy", 32'(busy), 32'd1);
      tick();
      chk("abort frame_err", 32'(frame_err), 32'd1);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort po_valid", 32'(po_valid), 32'd0);
      tick();
      chk("abort frame_err drop", 32'(frame_err), 32'd0);
      chk("abort po_count", 32'(po_count), exp_cnt());
      chk("abort po_data", po_data, 32'h0000_00C3);
      v = '{2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 5, 15, 32'h0000_1234};
      run_vec(v, "gap15 frame");
`else
      // Long in-frame gap is tolerated without the gap feature
      v = '{2'b00, 1'b1, 1'b1, 1'b0, 32'h0000_0081, 4, 40, 32'h0000_0081};
      run_vec(v, "longgap");
`endif

      // Enough short frames to wrap the 4-bit counter
      for (int k = 0; k < 6; k++) begin
         v = '{2'b00, 1'b1, 1'b1, 1'b0, 32'(8'h11 * (k + 1)), 0, 0, 32'(8'h11 * (k + 1))};
         run_vec(v, $sformatf("wrap%0d", k));
      end

      // Reset mid-frame discards the partial frame
      cfg_load = 1'b1; cfg_length = 2'b01; cfg_msb = 1'b1;
      tick();
      cfg_load = 1'b0;
      w16 = 16'hABCD;
      for (int i = 0; i < 10; i++) send_bit(w16[15-i]);
      chk("prerst busy", 32'(busy), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_count = 0;
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst po_valid", 32'(po_valid), 32'd0);
      chk("midrst po_count", 32'(po_count), 32'd0);
      chk("midrst frame_err", 32'(frame_err), 32'd0);
      for (int g = 0; g < 3; g++) begin
         tick();
         chk("postrst po_valid", 32'(po_valid), 32'd0);
      end
      v = '{2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_BEEF, 0, 0, 32'h0000_BEEF};
      run_vec(v, "beef");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
